// File: rtl/hazard3_ahb_arb_nmaster_pkg.sv
// Shared AHB encodings and helpers for the N-master arbiter.
package hazard3_ahb_arb_nmaster_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NSEQ   = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Upper bound on master count; one-hot helpers are sized to this.
    localparam int MAX_MASTERS = 8;

    // Binary index of a one-hot vector (0 when the vector is zero).
    function automatic logic [2:0] onehot_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/hazard3_rr_pick.sv
// Rotate-priority picker: the first requester strictly after ptr, wrapping,
// wins. Tying ptr to N-1 makes index 0 the highest priority (fixed priority).
module hazard3_rr_pick #(
    parameter int N     = 3,
    parameter int W_PTR = 2
) (
    input  logic [N-1:0]     req,
    input  logic [W_PTR-1:0] ptr,
    output logic [N-1:0]     gnt
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [W_PTR:0]   shamt;
    logic [2*N-1:0]   req_dbl;
    logic [2*N-1:0]   gnt_dbl;
    logic [N-1:0]     req_rot;
    logic [N-1:0]     gnt_rot;

    // Rotate so slot ptr+1 lands at bit 0, take lowest set bit, rotate back.
    always_comb begin
        shamt   = {1'b0, ptr} + 1'b1;
        req_dbl = {req, req} >> shamt;
        req_rot = req_dbl[N-1:0];
        gnt_rot = req_rot & (~req_rot + ONE);
        gnt_dbl = {gnt_rot, gnt_rot} << shamt;
        gnt     = gnt_dbl[2*N-1:N];
    end

endmodule

// File: rtl/hazard3_ahb_arb_nmaster.sv
// N-master to single AHB5 manager-port arbiter. Address phases are muxed from
// the combinationally granted master; data-phase responses are routed by the
// grant registered when the address phase completed. A stalled address phase
// keeps its grant, and a per-master starvation timer can boost a long-waiting
// requester above the normal priority order.
module hazard3_ahb_arb_nmaster
    import hazard3_ahb_arb_nmaster_pkg::*;
#(
    parameter int N_MASTERS     = 3,
    parameter int W_ADDR        = 32,
    parameter int W_DATA        = 32,
    parameter int RR_MODE       = 0,
    parameter int STARVE_CYCLES = 16,
    parameter int W_STARVE      = 5,
    localparam int W_HMASTER    = $clog2(N_MASTERS)
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS*W_ADDR-1:0]   m_addr,
    input  logic [N_MASTERS-1:0]          m_write,
    input  logic [N_MASTERS*3-1:0]        m_size,
    input  logic [N_MASTERS*4-1:0]        m_prot,
    input  logic [N_MASTERS-1:0]          m_excl,
    input  logic [N_MASTERS*W_DATA-1:0]   m_wdata,
    output logic [N_MASTERS-1:0]          m_aph_ready,
    output logic [N_MASTERS-1:0]          m_dph_ready,
    output logic [N_MASTERS-1:0]          m_dph_err,
    output logic [N_MASTERS-1:0]          m_dph_exokay,
    output logic [W_DATA-1:0]             m_rdata,

    output logic [W_ADDR-1:0]             haddr,
    output logic                          hwrite,
    output logic [1:0]                    htrans,
    output logic [2:0]                    hsize,
    output logic [2:0]                    hburst,
    output logic [3:0]                    hprot,
    output logic                          hmastlock,
    output logic                          hexcl,
    output logic [W_HMASTER-1:0]          hmaster,
    output logic [W_DATA-1:0]             hwdata,
    input  logic                          hready,
    input  logic                          hresp,
    input  logic                          hexokay,
    input  logic [W_DATA-1:0]             hrdata
);

    localparam logic [N_MASTERS-1:0] ONE       = {{(N_MASTERS-1){1'b0}}, 1'b1};
    localparam logic [W_HMASTER-1:0] PTR_FIXED = W_HMASTER'(N_MASTERS - 1);

    logic                   hold_aph;
    logic [N_MASTERS-1:0]   gnt_prev;
    logic [N_MASTERS-1:0]   dph_gnt;
    logic [W_HMASTER-1:0]   rr_ptr;
    logic [W_HMASTER-1:0]   pick_ptr;
    logic [N_MASTERS-1:0]   pick_gnt;
    logic [N_MASTERS-1:0]   starved;
    logic [N_MASTERS-1:0]   starved_gnt;
    logic [N_MASTERS-1:0]   gnt;
    logic [W_HMASTER-1:0]   gnt_idx;

    assign pick_ptr = (RR_MODE != 0) ? rr_ptr : PTR_FIXED;

    hazard3_rr_pick #(
        .N     (N_MASTERS),
        .W_PTR (W_HMASTER)
    ) u_pick (
        .req (m_req),
        .ptr (pick_ptr),
        .gnt (pick_gnt)
    );

    // Grant: held through a stalled aph, else starved boost, else normal pick.
    // Reset forces no grant so handshakes and htrans go quiet immediately.
    always_comb begin
        starved_gnt = starved & (~starved + ONE);
        if (rst)
            gnt = '0;
        else if (hold_aph)
            gnt = gnt_prev;
        else if (|starved)
            gnt = starved_gnt;
        else
            gnt = pick_gnt;
        gnt_idx = W_HMASTER'(onehot_idx(8'(gnt)));
    end

    // Arbitration state: aph hold, previous grant, dph owner, RR pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_aph <= 1'b0;
            gnt_prev <= '0;
            dph_gnt  <= '0;
            rr_ptr   <= PTR_FIXED;
        end else begin
            // An error response releases the hold so the master can re-arbitrate.
            hold_aph <= htrans[1] && !hready && !hresp;
            gnt_prev <= gnt;
            if (hready)
                dph_gnt <= gnt;
            if (hready && |gnt)
                rr_ptr <= gnt_idx;
        end
    end

    generate
        if (STARVE_CYCLES != 0) begin : g_starve
            localparam logic [W_STARVE-1:0] STARVE_MAX = W_STARVE'(STARVE_CYCLES);
            for (genvar i = 0; i < N_MASTERS; i++) begin : g_cnt
                logic [W_STARVE-1:0] cnt;
                // Count cycles spent requesting without acceptance, saturating.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)
                        cnt <= '0;
                    else if (!m_req[i] || m_aph_ready[i])
                        cnt <= '0;
                    else if (cnt != STARVE_MAX)
                        cnt <= cnt + 1'b1;
                end
                assign starved[i] = (cnt == STARVE_MAX);
            end
        end else begin : g_no_starve
            assign starved = '0;
        end
    endgenerate

    // Address-phase mux from the granted master; all-zero when nothing granted.
    always_comb begin
        haddr  = '0;
        hwrite = 1'b0;
        hsize  = '0;
        hprot  = '0;
        hexcl  = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (gnt[i]) begin
                haddr  = m_addr[i*W_ADDR +: W_ADDR];
                hwrite = m_write[i];
                hsize  = m_size[i*3 +: 3];
                hprot  = m_prot[i*4 +: 4];
                hexcl  = m_excl[i];
            end
        end
    end

    // Write data follows the data-phase owner.
    always_comb begin
        hwdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (dph_gnt[i])
                hwdata = m_wdata[i*W_DATA +: W_DATA];
        end
    end

    assign htrans       = (|gnt) ? HTRANS_NSEQ : HTRANS_IDLE;
    assign hmaster      = gnt_idx;
    assign hburst       = HBURST_SINGLE;
    assign hmastlock    = 1'b0;

    assign m_aph_ready  = gnt     & {N_MASTERS{hready}};
    assign m_dph_ready  = dph_gnt & {N_MASTERS{hready}};
    assign m_dph_err    = dph_gnt & {N_MASTERS{hresp}};
    assign m_dph_exokay = dph_gnt & {N_MASTERS{hexokay}};
    assign m_rdata      = hrdata;

endmodule
